// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / branch / memory-wait stall and flush controller
//
// Purpose: resolves the pipeline hazards that operand forwarding cannot:
//   load-use (load in EX feeding the ID instruction), taken-branch squash,
//   and data-memory wait, plus a sticky memory-wait watchdog.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_valid, id_rs, id_rt     ID-stage instruction and its source registers
//   id_uses_rs, id_uses_rt     which sources the ID instruction actually reads
//   id_rd, id_load             ID destination and "is a load with RegWrite"
//   ex_branch_taken            branch resolved taken in EX
//   mem_req, mem_ready         data-memory handshake from the MEM stage
//   stall_pc, stall_ifid       hold PC and IF/ID
//   bubble_idex, flush_ifid    insert NOP into ID/EX, clear IF/ID
//   freeze_all                 hold every pipeline register
//   busy_vec                   one-hot OR of destinations of loads in EX/MEM
//   mem_timeout                sticky watchdog error
// Optional feature (macro HAZARD_PERF_CNT_EN): saturating 16-bit
//   perf_stall_cnt / perf_flush_cnt / perf_freeze_cnt outputs.
module hazard_stall_unit #(
    parameter int AW          = 2,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_load,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              freeze_all,
    output logic [2**AW-1:0]  busy_vec,
    output logic              mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt,
    output logic [15:0]       perf_freeze_cnt
`endif
);

    localparam int NR = 2**AW;
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic            ex_ld_v_q, ex_ld_v_d;
    logic [AW-1:0]   ex_rd_q, ex_rd_d;
    logic            mem_ld_v_q, mem_ld_v_d;
    logic [AW-1:0]   mem_rd_q, mem_rd_d;
    logic [0:0]      state_q, state_d;
    logic [TO_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    logic            freeze;
    logic            load_use;
    logic [NR-1:0]   busy;

    // Hazard detection and prioritised control; everything is forced low
    // while reset is held so the pipeline sees a quiet controller.
    always_comb begin
        freeze   = mem_req & ~mem_ready;
        // Only a load in EX can stall; a load in MEM is forwarded from WB.
        load_use = id_valid & ex_ld_v_q &
                   ((id_uses_rs & (id_rs == ex_rd_q)) |
                    (id_uses_rt & (id_rt == ex_rd_q)));

        busy = '0;
        if (ex_ld_v_q)  busy[ex_rd_q]  = 1'b1;
        if (mem_ld_v_q) busy[mem_rd_q] = 1'b1;

        freeze_all  = rst_n & freeze;
        flush_ifid  = rst_n & ~freeze & ex_branch_taken;
        bubble_idex = rst_n & ~freeze & (ex_branch_taken | load_use);
        // A taken branch squashes the ID instruction, so load-use is moot.
        stall_pc    = rst_n & ~freeze & ~ex_branch_taken & load_use;
        stall_ifid  = stall_pc;
        busy_vec    = rst_n ? busy : '0;
        mem_timeout = rst_n & timeout_q;
    end

    // Shadow of in-flight loads: mirrors ID->EX->MEM movement of the pipeline.
    always_comb begin
        ex_ld_v_d  = ex_ld_v_q;
        ex_rd_d    = ex_rd_q;
        mem_ld_v_d = mem_ld_v_q;
        mem_rd_d   = mem_rd_q;
        if (!freeze) begin
            mem_ld_v_d = ex_ld_v_q;
            mem_rd_d   = ex_rd_q;
            if (bubble_idex) begin
                ex_ld_v_d = 1'b0;
            end else begin
                ex_ld_v_d = id_valid & id_load;
                ex_rd_d   = id_rd;
            end
        end
    end

    // Memory-wait FSM and watchdog. The count only runs in WAIT, so the
    // first frozen cycle (still in RUN) is not counted.
    always_comb begin
        state_d   = state_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (freeze) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d  = ST_RUN;
                    wd_cnt_d = '0;
                end else begin
                    if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + TO_W'(1);
                    if (wd_cnt_d >= TO_W'(MEM_TIMEOUT)) timeout_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_ld_v_q  <= 1'b0;
            ex_rd_q    <= '0;
            mem_ld_v_q <= 1'b0;
            mem_rd_q   <= '0;
            state_q    <= ST_RUN;
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            ex_ld_v_q  <= ex_ld_v_d;
            ex_rd_q    <= ex_rd_d;
            mem_ld_v_q <= mem_ld_v_d;
            mem_rd_q   <= mem_rd_d;
            state_q    <= state_d;
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_flush_cnt  <= '0;
            perf_freeze_cnt <= '0;
        end else begin
            if (stall_pc && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (flush_ifid && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            if (freeze_all && perf_freeze_cnt != '1)
                perf_freeze_cnt <= perf_freeze_cnt + 16'd1;
        end
    end
`endif

endmodule
